// File: rtl/mux_lut_eval_pkg.sv
// Shared types and constants for the runtime-loadable mux/LUT function evaluator.
// Residue codes are 4-bit truth tables of (d, e), indexed by {e,d}.
package mux_lut_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int CODE_W = 4;

    localparam logic [CODE_W-1:0] CODE_ZERO = 4'b0000;
    localparam logic [CODE_W-1:0] CODE_ONE  = 4'b1111;
    localparam logic [CODE_W-1:0] CODE_D    = 4'b1010;
    localparam logic [CODE_W-1:0] CODE_DN   = 4'b0101;
    localparam logic [CODE_W-1:0] CODE_E    = 4'b1100;
    localparam logic [CODE_W-1:0] CODE_EN   = 4'b0011;

    function automatic logic [1:0] res_idx(input logic d, input logic e);
        return {e, d};
    endfunction

endpackage

// File: rtl/mux_lut_eval_table.sv
// Code table for mux_lut_eval: 2**SEL_W residue codes, serial write port,
// combinational single-bit read addressed by (sel, residue index).
module mux_lut_table
    import mux_lut_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_idx,
    input  logic [CODE_W-1:0] wr_code,
    input  logic [SEL_W-1:0]  rd_sel,
    input  logic [1:0]        rd_res,
    output logic              rd_bit
);

    localparam int DEPTH = 1 << SEL_W;

    logic [CODE_W-1:0] lut_r [DEPTH];
    logic [CODE_W-1:0] rd_entry_s;

    // Entry storage; a reload only overwrites the entries it reaches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                lut_r[i] <= CODE_ZERO;
            end
        end else if (wr_en) begin
            lut_r[wr_idx] <= wr_code;
        end else begin
            lut_r <= lut_r;
        end
    end

    assign rd_entry_s = lut_r[rd_sel];
    assign rd_bit     = rd_entry_s[rd_res];

endmodule

// File: rtl/mux_lut_eval.sv
// Sequential mux/LUT evaluator: serial table load FSM plus a 1-deep registered output.
// Optional hit counter enabled by defining MUX_LUT_EVAL_HITCNT_EN.
module mux_lut_eval
    import mux_lut_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CODE_W-1:0] cfg_data,
    output logic              configured,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  sel,
    input  logic [1:0]        res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              y
`ifdef MUX_LUT_EVAL_HITCNT_EN
    ,
    input  logic              hit_clr,
    output logic [15:0]       hit_cnt
`endif
);

    localparam logic [SEL_W-1:0] LAST_IDX = {SEL_W{1'b1}};

    state_t           state_r, state_nx_s;
    logic [SEL_W-1:0] idx_r, idx_nx_s;
    logic             configured_r, configured_nx_s;
    logic             out_valid_r, y_r;
    logic             wr_en_s, accept_s, lut_bit_s;

    // cfg_start overrides any beat or request presented in the same cycle.
    assign wr_en_s   = (state_r == LOAD) && cfg_valid && !cfg_start;
    assign cfg_ready = (state_r == LOAD);
    assign in_ready  = (state_r == RUN) && !cfg_start && (!out_valid_r || out_ready);
    assign accept_s  = in_valid && in_ready;

    mux_lut_table #(.SEL_W(SEL_W)) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .wr_idx  (idx_r),
        .wr_code (cfg_data),
        .rd_sel  (sel),
        .rd_res  (res_idx(res[0], res[1])),
        .rd_bit  (lut_bit_s)
    );

    // FSM, load index and configured flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= UNCFG;
            idx_r        <= '0;
            configured_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            idx_r        <= idx_nx_s;
            configured_r <= configured_nx_s;
        end
    end

    // Next-state logic; a table counts as configured only after its final entry lands.
    always_comb begin
        state_nx_s      = state_r;
        idx_nx_s        = idx_r;
        configured_nx_s = configured_r;
        if (cfg_start) begin
            state_nx_s      = LOAD;
            idx_nx_s        = '0;
            configured_nx_s = 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    if (wr_en_s && (idx_r == LAST_IDX)) begin
                        state_nx_s      = RUN;
                        idx_nx_s        = '0;
                        configured_nx_s = 1'b1;
                    end else if (wr_en_s) begin
                        idx_nx_s = idx_r + SEL_W'(1'b1);
                    end else begin
                        idx_nx_s = idx_r;
                    end
                end
                UNCFG, RUN: begin
                    state_nx_s = state_r;
                end
                default: begin
                    state_nx_s      = UNCFG;
                    idx_nx_s        = '0;
                    configured_nx_s = 1'b0;
                end
            endcase
        end
    end

    // Output register: holds y while the consumer stalls, drains across reloads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            y_r         <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            y_r         <= lut_bit_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            y_r         <= y_r;
        end else begin
            out_valid_r <= out_valid_r;
            y_r         <= y_r;
        end
    end

    assign configured = configured_r;
    assign out_valid  = out_valid_r;
    assign y          = y_r;

`ifdef MUX_LUT_EVAL_HITCNT_EN
    logic [15:0] hit_cnt_r;

    // Saturating count of accepted evaluations yielding 1; clear beats increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_r <= 16'h0000;
        end else if (hit_clr) begin
            hit_cnt_r <= 16'h0000;
        end else if (accept_s && lut_bit_s && (hit_cnt_r != 16'hFFFF)) begin
            hit_cnt_r <= hit_cnt_r + 16'h0001;
        end else begin
            hit_cnt_r <= hit_cnt_r;
        end
    end

    assign hit_cnt = hit_cnt_r;
`endif

endmodule

// File: doc/mux_lut_eval.md
Name: mux_lut_eval

Overview:
- Parametrised, sequential successor to the lab's 8:1-mux function realisation.
- Evaluates a boolean function of SEL_W+2 variables. The high variables drive the mux select. Each mux input is an arbitrary function of the two residual variables (d, e), stored as a runtime-loadable 4-bit code.
- Code table is loaded serially through a valid/ready port. Evaluations flow through a valid/ready pipeline with a registered output.
- Sits between stimulus logic and the result checker in the Prelim lab datapaths.

Parameters:
- SEL_W, 3: number of select variables; table depth = 2**SEL_W entries (legal 1..6).
- CODE_W, 4: residue code width; fixed at 4 (truth table of 2 residual variables); kept for package visibility.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  pulse: begin a table reload.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  table accepts an entry.
- cfg_data  in  4  residue code for the current entry.
- configured  out  1  a complete table is loaded.
- in_valid  in  1  evaluation request valid.
- in_ready  out  1  evaluator accepts a request.
- sel  in  SEL_W  select variables; sel[SEL_W-1] is the MSB, e.g. a,b,c for SEL_W=3.
- res  in  2  residual variables, res[0]=d, res[1]=e.
- out_valid  out  1  y valid.
- out_ready  in  1  consumer accepts y.
- y  out  1  function value.

Behaviour:
- Reset (async, rst=1):
  - state=UNCFG; all table entries = 4'b0000; load index = 0.
  - Outputs: out_valid=0, y=0, configured=0, cfg_ready=0, in_ready=0.
- Code semantics: y = table[sel][{e,d}].
  - bit0: d=0,e=0. bit1: d=1,e=0. bit2: d=0,e=1. bit3: d=1,e=1.
  - Examples: d -> 4'b1010; ~d -> 4'b0101; ~e&d -> 4'b0010; 0 -> 4'b0000; 1 -> 4'b1111.
- FSM states: UNCFG, LOAD, RUN.
  - UNCFG: cfg_ready=0, in_ready=0. cfg_start -> LOAD.
  - LOAD:
    - cfg_ready=1, in_ready=0.
    - Each cfg_valid&cfg_ready writes table[idx] and increments idx (entry 0 first).
    - On write of entry 2**SEL_W-1: idx wraps to 0, go to RUN, configured=1 on the next cycle.
  - RUN: cfg_ready=0. cfg_start -> LOAD.
- Entering LOAD (from any state, cfg_start sampled high):
  - idx=0; configured=0 from the next cycle.
  - Old table contents are retained until overwritten.
  - cfg_start during LOAD restarts at idx=0.
  - Partial loads never reach RUN.
- Evaluation:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - On in_valid&in_ready, y and out_valid=1 are registered. Latency is exactly 1 cycle.
  - Full throughput: one result per cycle while out_ready=1.
  - out_valid holds and y is stable while out_valid&!out_ready.
  - out_valid clears on out_ready when no new request is accepted that cycle.
- A pending output survives cfg_start and drains normally; no new requests are accepted until RUN.
- Simultaneous cfg_start and in_valid in RUN: cfg_start wins. The request is not accepted, because in_ready is combinationally forced to 0 by cfg_start.
- Reset mid-load or mid-output: immediate return to the reset values above.

Optional Feature:
- Macro: MUX_LUT_EVAL_HITCNT_EN.
- Defined:
  - Adds output port hit_cnt [15:0] and input port hit_clr.
  - hit_cnt counts accepted evaluations producing y=1.
  - Saturates at 16'hFFFF; clears on rst or hit_clr. hit_clr has priority over a same-cycle increment.
- Undefined: the ports and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mux_lut_pkg:
  - state enum (UNCFG, LOAD, RUN).
  - CODE_W=4.
  - Named code constants: CODE_ZERO, CODE_ONE, CODE_D, CODE_DN, CODE_E, CODE_EN.
  - Function res_idx(d,e).
- One sub-module, mux_lut_table: holds the 2**SEL_W x 4 register array, serial write port, combinational read (sel, res) -> bit.
- FSM and output register live in mux_lut_eval.

Test Plan:
- Reset, then in_valid=1 with no load -> in_ready=0, out_valid=0, configured=0 for 20 cycles.
- SEL_W=3 load of the lab function [CODE_D, 0010, 0001, 0001, 1110, 0001, 0101, 1101] -> configured=1 one cycle after the 8th beat. Then sweep all 32 {a,b,c,e,d} back-to-back with out_ready=1 -> y matches the golden model, one per cycle, latency 1.
- out_ready held 0 for 5 cycles with in_valid=1 -> y stable, in_ready=0, exactly one result delivered on release, none dropped or duplicated.
- cfg_start after 3 beats, then a full 8-beat reload of all 4'b1111 -> every evaluation gives y=1; no evaluation is accepted during LOAD.
- cfg_start and in_valid in the same RUN cycle -> request not accepted, state=LOAD next cycle, pending output still drains.
- MUX_LUT_EVAL_HITCNT_EN: 10 accepted evaluations with 6 ones -> hit_cnt=6; hit_clr with a concurrent y=1 acceptance -> hit_cnt=0. Preload 16'hFFFE plus 3 ones -> 16'hFFFF.
